// File: rtl/sht40_meas_sched.sv
// SHT40 periodic measurement scheduler: command, conversion wait, 6-byte readback, publish.
// Define SHT40_CRC_EN to build CRC-8 checking of the readback words; otherwise words are always accepted.
module sht40_meas_sched #(
  parameter int unsigned PERIOD_CYC = 100_000_000,
  parameter int unsigned CONV_CYC   = 1_000_000,
  parameter int unsigned STROBE_CYC = 16,
  parameter logic [7:0]  MEAS_CMD   = 8'hFD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic        o_req,
  output logic        o_rd,
  output logic [7:0]  o_wbyte,
  input  logic        i_rvalid,
  input  logic [7:0]  i_rdata,
  input  logic        i_done,
  input  logic        i_err,
  output logic [15:0] o_temp,
  output logic [15:0] o_rh,
  output logic        o_r_temp,
  output logic        o_r_rh,
  output logic        o_busy,
  output logic [7:0]  o_crc_err_cnt,
  output logic [7:0]  o_bus_err_cnt
);

  localparam int unsigned PER_W  = $clog2(PERIOD_CYC + 1);
  localparam int unsigned CONV_W = $clog2(CONV_CYC + 1);
  localparam int unsigned STB_W  = $clog2(STROBE_CYC + 1);
  localparam int unsigned NBYTES = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_CONV,
    S_READ,
    S_CHECK
  } state_t;

  state_t             state;
  logic [PER_W-1:0]   per_cnt;
  logic [CONV_W-1:0]  conv_cnt;
  logic [2:0]         byte_idx;
  logic [7:0]         rx_byte [NBYTES];
  logic [STB_W-1:0]   stb_t_cnt;
  logic [STB_W-1:0]   stb_r_cnt;

  logic        rx_take_c;
  logic [2:0]  byte_cnt_c;
  logic [15:0] temp_word_c;
  logic [15:0] rh_word_c;
  logic        temp_ok_c;
  logic        rh_ok_c;
  logic        pub_temp_c;
  logic        pub_rh_c;
  logic        bus_fail_c;

  // A byte arriving with i_done counts toward the frame length.
  assign rx_take_c   = (state == S_READ) && i_rvalid && (byte_idx < 3'(NBYTES));
  assign byte_cnt_c  = byte_idx + 3'(rx_take_c);
  assign temp_word_c = {rx_byte[0], rx_byte[1]};
  assign rh_word_c   = {rx_byte[3], rx_byte[4]};
  assign pub_temp_c  = (state == S_CHECK) && temp_ok_c;
  assign pub_rh_c    = (state == S_CHECK) && rh_ok_c;
  assign bus_fail_c  = ((state == S_CMD) && !i_done && i_err) ||
                       ((state == S_READ) && ((i_done && (byte_cnt_c != 3'(NBYTES))) ||
                                              (!i_done && i_err)));

`ifdef SHT40_CRC_EN
  logic [1:0] crc_fail_c;
  logic [8:0] crc_sum_c;

  // CRC-8, poly 0x31, init 0xFF, MSB first, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ ({8{fb}} & 8'h31);
    end
    return c;
  endfunction

  assign temp_ok_c  = (crc8(temp_word_c) == rx_byte[2]);
  assign rh_ok_c    = (crc8(rh_word_c) == rx_byte[5]);
  assign crc_fail_c = 2'(!temp_ok_c) + 2'(!rh_ok_c);
  assign crc_sum_c  = {1'b0, o_crc_err_cnt} + 9'(crc_fail_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_crc_err_cnt <= 8'd0;
    end else if (state == S_CHECK) begin
      o_crc_err_cnt <= (crc_sum_c > 9'd255) ? 8'hFF : crc_sum_c[7:0];
    end
  end
`else
  assign temp_ok_c     = 1'b1;
  assign rh_ok_c       = 1'b1;
  assign o_crc_err_cnt = 8'd0;
`endif

  // Measurement sequencer; the period counter runs in every state so starts stay evenly spaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      per_cnt  <= '0;
      conv_cnt <= '0;
      byte_idx <= '0;
      o_req    <= 1'b0;
      o_rd     <= 1'b0;
      o_wbyte  <= 8'd0;
      o_busy   <= 1'b0;
      for (int i = 0; i < int'(NBYTES); i++) rx_byte[i] <= 8'd0;
    end else begin
      if ((state == S_IDLE) && (per_cnt == '0) && i_en) begin
        per_cnt <= PER_W'(PERIOD_CYC - 1);
      end else if (per_cnt != '0) begin
        per_cnt <= per_cnt - PER_W'(1);
      end

      case (state)
        S_IDLE: begin
          if ((per_cnt == '0) && i_en) begin
            state   <= S_CMD;
            o_req   <= 1'b1;
            o_rd    <= 1'b0;
            o_wbyte <= MEAS_CMD;
            o_busy  <= 1'b1;
          end
        end
        S_CMD: begin
          if (i_done) begin
            o_req    <= 1'b0;
            conv_cnt <= CONV_W'(CONV_CYC - 1);
            state    <= S_CONV;
          end else if (i_err) begin
            o_req  <= 1'b0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_CONV: begin
          if (conv_cnt == '0) begin
            state    <= S_READ;
            o_req    <= 1'b1;
            o_rd     <= 1'b1;
            byte_idx <= '0;
          end else begin
            conv_cnt <= conv_cnt - CONV_W'(1);
          end
        end
        S_READ: begin
          if (rx_take_c) begin
            rx_byte[byte_idx] <= i_rdata;
            byte_idx          <= byte_cnt_c;
          end
          if (i_done || i_err) begin
            o_req <= 1'b0;
            if (i_done && (byte_cnt_c == 3'(NBYTES))) begin
              state <= S_CHECK;
            end else begin
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_CHECK: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_req  <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating transaction-failure counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bus_err_cnt <= 8'd0;
    end else if (bus_fail_c && (o_bus_err_cnt != 8'hFF)) begin
      o_bus_err_cnt <= o_bus_err_cnt + 8'd1;
    end
  end

  // Output words and their fixed-width publish strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_temp    <= 16'd0;
      o_rh      <= 16'd0;
      o_r_temp  <= 1'b0;
      o_r_rh    <= 1'b0;
      stb_t_cnt <= '0;
      stb_r_cnt <= '0;
    end else begin
      if (pub_temp_c) begin
        o_temp    <= temp_word_c;
        o_r_temp  <= 1'b1;
        stb_t_cnt <= STB_W'(STROBE_CYC - 1);
      end else if (stb_t_cnt != '0) begin
        stb_t_cnt <= stb_t_cnt - STB_W'(1);
      end else begin
        o_r_temp <= 1'b0;
      end

      if (pub_rh_c) begin
        o_rh      <= rh_word_c;
        o_r_rh    <= 1'b1;
        stb_r_cnt <= STB_W'(STROBE_CYC - 1);
      end else if (stb_r_cnt != '0) begin
        stb_r_cnt <= stb_r_cnt - STB_W'(1);
      end else begin
        o_r_rh <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sht40_meas_sched.sv
// Scoreboard bench for sht40_meas_sched: a master model issues frames and queues expected
// publishes; a strobe monitor pops and checks word, start cycle and strobe width.
module tb_sht40_meas_sched;

  localparam int unsigned P     = 200;
  localparam int unsigned C     = 20;
  localparam int unsigned S     = 16;
  localparam int          LIMIT = 400;
`ifdef SHT40_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        o_req;
  logic        o_rd;
  logic [7:0]  o_wbyte;
  logic        i_rvalid;
  logic [7:0]  i_rdata;
  logic        i_done;
  logic        i_err;
  logic [15:0] o_temp;
  logic [15:0] o_rh;
  logic        o_r_temp;
  logic        o_r_rh;
  logic        o_busy;
  logic [7:0]  o_crc_err_cnt;
  logic [7:0]  o_bus_err_cnt;

  sht40_meas_sched #(
    .PERIOD_CYC(P),
    .CONV_CYC  (C),
    .STROBE_CYC(S),
    .MEAS_CMD  (8'hFD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (i_en),
    .o_req        (o_req),
    .o_rd         (o_rd),
    .o_wbyte      (o_wbyte),
    .i_rvalid     (i_rvalid),
    .i_rdata      (i_rdata),
    .i_done       (i_done),
    .i_err        (i_err),
    .o_temp       (o_temp),
    .o_rh         (o_rh),
    .o_r_temp     (o_r_temp),
    .o_r_rh       (o_r_rh),
    .o_busy       (o_busy),
    .o_crc_err_cnt(o_crc_err_cnt),
    .o_bus_err_cnt(o_bus_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  exp_t tq[$];
  exp_t rq[$];
  int   checks = 0;
  int   errors = 0;
  int   last_done_cyc = 0;
  int   prev_start = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_req(output int at);
    int n = 0;
    while (!o_req && n < LIMIT) begin
      tick();
      n++;
    end
    check("req_seen", 32'(o_req), 32'd1);
    at = cyc;
  endtask

  // Write transaction for the measure command; err selects NACK instead of completion.
  task automatic serve_cmd(input bit err, output int st);
    wait_req(st);
    check("cmd_rd", 32'(o_rd), 32'd0);
    check("cmd_wbyte", 32'(o_wbyte), 32'hFD);
    check("cmd_busy", 32'(o_busy), 32'd1);
    tick();
    tick();
    if (err) i_err = 1'b1;
    else i_done = 1'b1;
    last_done_cyc = cyc;
    tick();
    i_done = 1'b0;
    i_err  = 1'b0;
    check("cmd_req_drop", 32'(o_req), 32'd0);
  endtask

  // Read transaction returning n bytes of fr (MSB byte first); same puts i_done on the last byte.
  task automatic serve_read(input logic [55:0] fr, input int n, input bit same,
                            input bit t_ok, input bit r_ok);
    int rc;
    int dc;
    wait_req(rc);
    check("conv_wait", 32'(rc - last_done_cyc), 32'(C + 1));
    check("read_rd", 32'(o_rd), 32'd1);
    tick();
    dc = 0;
    for (int k = 0; k < n; k++) begin
      i_rvalid = 1'b1;
      i_rdata  = fr[55-8*k -: 8];
      if (same && k == n - 1) begin
        i_done = 1'b1;
        dc = cyc;
      end
      tick();
    end
    i_rvalid = 1'b0;
    i_rdata  = 8'h00;
    if (!same) begin
      i_done = 1'b1;
      dc = cyc;
      tick();
    end
    i_done = 1'b0;
    check("read_req_drop", 32'(o_req), 32'd0);
    if (n >= 6) begin
      if (t_ok) tq.push_back('{val: fr[55:40], at: dc + 2});
      if (r_ok) rq.push_back('{val: fr[31:16], at: dc + 2});
    end
  endtask

  task automatic run(input bit err, input logic [55:0] fr, input int n, input bit same,
                     input bit t_ok, input bit r_ok);
    int st;
    serve_cmd(err, st);
    check("start_spacing", 32'(st - prev_start), 32'(P));
    prev_start = st;
    if (!err) serve_read(fr, n, same, t_ok, r_ok);
  endtask

  // Strobe monitor: each rising strobe pops one expectation; each falling strobe checks width.
  logic [1:0] stb_prev = 2'b00;
  int         width [2];
  always @(negedge clk) begin
    logic [1:0]  stb;
    logic [15:0] word;
    exp_t        e;
    bit          have;
    stb = {o_r_rh, o_r_temp};
    for (int ch = 0; ch < 2; ch++) begin
      word = (ch == 0) ? o_temp : o_rh;
      if (stb[ch] && !stb_prev[ch]) begin
        have = 1'b0;
        if (ch == 0 && tq.size() > 0) begin e = tq.pop_front(); have = 1'b1; end
        if (ch == 1 && rq.size() > 0) begin e = rq.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
          errors++;
          $display("FAIL strobe_unexpected ch=%0d actual=%0h required=no strobe (cycle %0d)", ch, word, cyc);
        end else if (word !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL publish ch=%0d actual=%0h@%0d required=%0h@%0d", ch, word, cyc, e.val, e.at);
        end
        width[ch] = 1;
      end else if (stb[ch]) begin
        width[ch]++;
      end else if (stb_prev[ch]) begin
        checks++;
        if (width[ch] != int'(S)) begin
          errors++;
          $display("FAIL strobe_width ch=%0d actual=%0d required=%0d", ch, width[ch], S);
        end
      end
    end
    stb_prev = stb;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int st;
    int rel;
    rst      = 1'b1;
    i_en     = 1'b1;
    i_rvalid = 1'b0;
    i_rdata  = 8'h00;
    i_done   = 1'b0;
    i_err    = 1'b0;
    repeat (3) tick();
    check("rst_req", 32'(o_req), 32'd0);
    check("rst_rd", 32'(o_rd), 32'd0);
    check("rst_wbyte", 32'(o_wbyte), 32'd0);
    check("rst_temp", 32'(o_temp), 32'd0);
    check("rst_rh", 32'(o_rh), 32'd0);
    check("rst_strobes", 32'({o_r_temp, o_r_rh}), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_counts", 32'({o_crc_err_cnt, o_bus_err_cnt}), 32'd0);

    // First start one cycle after reset release with i_en already high.
    rst = 1'b0;
    rel = cyc;
    serve_cmd(1'b0, st);
    check("first_start", 32'(st - rel), 32'd1);
    prev_start = st;
    serve_read(56'hBEEF92666693_00, 6, 1'b0, 1'b1, 1'b1);
    tick();
    check("f1_temp", 32'(o_temp), 32'hBEEF);
    check("f1_crc_cnt", 32'(o_crc_err_cnt), 32'd0);

    // Corrupted temperature CRC.
    run(1'b0, 56'hBEEF00666693_00, 6, 1'b0, !CRC_ON, 1'b1);
    tick();
    check("f2_temp", 32'(o_temp), 32'hBEEF);
    check("f2_crc_cnt", 32'(o_crc_err_cnt), CRC_ON ? 32'd1 : 32'd0);

    // NACK on command, then a short read.
    run(1'b1, 56'h0, 0, 1'b0, 1'b0, 1'b0);
    check("bus_err_nack", 32'(o_bus_err_cnt), 32'd1);
    run(1'b0, 56'hBEEF92666693_00, 4, 1'b0, 1'b0, 1'b0);
    check("bus_err_short", 32'(o_bus_err_cnt), 32'd2);

    // Sixth byte together with i_done, then a seven-byte read.
    run(1'b0, 56'h000081BEEF92_00, 6, 1'b1, 1'b1, 1'b1);
    run(1'b0, 56'h66669300_0081FF, 7, 1'b0, 1'b1, 1'b1);
    tick();
    check("f4_temp", 32'(o_temp), 32'h6666);
    check("f4_rh", 32'(o_rh), 32'h0000);
    check("bus_err_hold", 32'(o_bus_err_cnt), 32'd2);

    // Reset in the middle of the conversion wait.
    serve_cmd(1'b0, st);
    check("spacing_pre_rst", 32'(st - prev_start), 32'(P));
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_req", 32'(o_req), 32'd0);
    check("mid_rst_temp", 32'(o_temp), 32'd0);
    check("mid_rst_bus_cnt", 32'(o_bus_err_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    rel = cyc;
    serve_cmd(1'b0, st);
    check("restart", 32'(st - rel), 32'd1);
    prev_start = st;
    serve_read(56'hBEEF92666693_00, 6, 1'b0, 1'b1, 1'b1);

    // 150 frames with both CRCs wrong drive the CRC error count to saturation.
    for (int i = 0; i < 150; i++) begin
      run(1'b0, 56'h0, 6, 1'b0, !CRC_ON, !CRC_ON);
    end
    repeat (S + 5) tick();
    check("crc_saturate", 32'(o_crc_err_cnt), CRC_ON ? 32'd255 : 32'd0);
    check("bus_err_final", 32'(o_bus_err_cnt), 32'd0);
    check("queues_drained", 32'(tq.size() + rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
